demux2_stream: RTL and testbench

Registered 1-to-2 stream demultiplexer for the 16-bit CPU datapath, the routing counterpart of the 2:1 select mux. A single valid/ready input stream carries a data word plus a destination select bit. Each word is steered into one of two independent 2-entry output buffers, and each buffer drains through its own valid/ready port. Per-port wrap-around word counters support debug and verification.

---
 rtl/demux2_stream.sv | 85 ++++++++
 tb/tb_demux2_stream.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux2_stream.sv
// rtl/demux2_stream.sv - registered 1-to-2 stream demultiplexer with 2-entry per-port buffers
module demux2_stream #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1
);

  logic [WIDTH-1:0] mem [2][2];
  logic [1:0]       occ [2];
  logic [15:0]      cnt [2];
  logic [1:0]       rd_ptr;
  logic [1:0]       wr_ptr;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       ready_in;

  // Readiness depends only on the selected buffer's occupancy, never on sink ready.
  assign in_ready = (in_sel ? occ[1] : occ[0]) != 2'd2;

  assign push[0] = in_valid && in_ready && !in_sel;
  assign push[1] = in_valid && in_ready && in_sel;

  assign ready_in[0] = out0_ready;
  assign ready_in[1] = out1_ready;

  assign out0_valid = occ[0] != 2'd0;
  assign out1_valid = occ[1] != 2'd0;
  assign out0_data  = mem[0][rd_ptr[0]];
  assign out1_data  = mem[1][rd_ptr[1]];

  assign pop[0] = out0_valid && ready_in[0];
  assign pop[1] = out1_valid && ready_in[1];

  assign cnt0 = cnt[0];
  assign cnt1 = cnt[1];

  // Data storage carries no reset; stale entries are masked by zero occupancy.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (push[k]) begin
        mem[k][wr_ptr[k]] <= in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= 2'b00;
      wr_ptr <= 2'b00;
      for (int k = 0; k < 2; k++) begin
        occ[k] <= 2'd0;
        cnt[k] <= 16'd0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (push[k]) begin
          wr_ptr[k] <= ~wr_ptr[k];
        end
        if (pop[k]) begin
          rd_ptr[k] <= ~rd_ptr[k];
          cnt[k]    <= cnt[k] + 16'd1;
        end
        case ({push[k], pop[k]})
          2'b10:   occ[k] <= occ[k] + 2'd1;
          2'b01:   occ[k] <= occ[k] - 2'd1;
          default: occ[k] <= occ[k];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_demux2_stream.sv
// tb/tb_demux2_stream.sv - self-checking bench for demux2_stream
module tb_demux2_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out0_data;
  logic        out0_valid;
  logic        out0_ready;
  logic [15:0] out1_data;
  logic        out1_valid;
  logic        out1_ready;
  logic [15:0] cnt0;
  logic [15:0] cnt1;

  int checks   = 0;
  int failures = 0;

  demux2_stream #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: two bounded queues of accepted words plus pop tallies.
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] m_cnt0, m_cnt1;
  bit          model_live = 0;

  always @(posedge clk) begin
    bit p0, p1, d0, d1;
    if (rst) begin
      q0.delete();
      q1.delete();
      m_cnt0     = 16'd0;
      m_cnt1     = 16'd0;
      model_live = 1;
    end else if (model_live) begin
      p0 = in_valid && !in_sel && (q0.size() < 2);
      p1 = in_valid &&  in_sel && (q1.size() < 2);
      d0 = (q0.size() > 0) && out0_ready;
      d1 = (q1.size() > 0) && out1_ready;
      if (d0) begin void'(q0.pop_front()); m_cnt0 = m_cnt0 + 16'd1; end
      if (d1) begin void'(q1.pop_front()); m_cnt1 = m_cnt1 + 16'd1; end
      if (p0) q0.push_back(in_data);
      if (p1) q1.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("model_out0_valid", {31'd0, out0_valid}, {31'd0, q0.size() != 0});
      chk("model_out1_valid", {31'd0, out1_valid}, {31'd0, q1.size() != 0});
      if (q0.size() != 0) chk("model_out0_data", {16'd0, out0_data}, {16'd0, q0[0]});
      if (q1.size() != 0) chk("model_out1_data", {16'd0, out1_data}, {16'd0, q1[0]});
      chk("model_in_ready", {31'd0, in_ready},
          {31'd0, (in_sel ? q1.size() : q0.size()) < 2});
      chk("model_cnt0", {16'd0, cnt0}, {16'd0, m_cnt0});
      chk("model_cnt1", {16'd0, cnt1}, {16'd0, m_cnt1});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 16'hDEAD;
    out0_ready = 1'b1; out1_ready = 1'b1;

    // Reset held two cycles with input valid
    step();
    at_neg();
    chk("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
    chk("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
    chk("rst_cnt0", {16'd0, cnt0}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    rst = 1'b0; in_valid = 1'b0;
    at_neg();
    chk("rst_nothing_stored0", {31'd0, out0_valid}, 32'd0);
    chk("rst_nothing_stored1", {31'd0, out1_valid}, 32'd0);
    chk("rst_cnt1", {16'd0, cnt1}, 32'd0);

    // Routing
    in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h1111;
    step();
    in_sel = 1'b1; in_data = 16'h2222;
    at_neg();
    chk("route_p0_valid", {31'd0, out0_valid}, 32'd1);
    chk("route_p0_data", {16'd0, out0_data}, 32'h1111);
    step();
    in_valid = 1'b0;
    at_neg();
    chk("route_p1_data", {16'd0, out1_data}, 32'h2222);
    chk("route_cnt0", {16'd0, cnt0}, 32'd1);
    step();
    at_neg();
    chk("route_cnt1", {16'd0, cnt1}, 32'd1);

    // Backpressure on port 0
    out0_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 16'hA001;
    step();
    in_data = 16'hA002;
    step();
    in_data = 16'hA003;
    at_neg();
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    step();
    out0_ready = 1'b1;
    at_neg();
    chk("bp_head_A001", {16'd0, out0_data}, 32'hA001);
    step();
    at_neg();
    chk("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
    chk("bp_head_A002", {16'd0, out0_data}, 32'hA002);
    step();
    in_valid = 1'b0;
    at_neg();
    chk("bp_head_A003", {16'd0, out0_data}, 32'hA003);
    step();
    at_neg();
    chk("bp_drained", {31'd0, out0_valid}, 32'd0);

    // Port independence: port 0 full and stalled
    out0_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 16'hC001;
    step();
    in_data = 16'hC002;
    step();
    in_sel = 1'b1; in_data = 16'hB0B0;
    at_neg();
    chk("indep_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    at_neg();
    chk("indep_p1_valid", {31'd0, out1_valid}, 32'd1);
    chk("indep_p1_data", {16'd0, out1_data}, 32'hB0B0);
    chk("indep_p0_held", {16'd0, out0_data}, 32'hC001);
    step();
    out0_ready = 1'b1;
    step();
    step();

    // Simultaneous push and pop at occupancy 1 on port 1
    in_valid = 1'b1; in_sel = 1'b1; in_data = 16'h5000;
    step();
    for (int i = 1; i <= 8; i++) begin
      in_data = 16'h5000 + 16'(i);
      at_neg();
      chk("pp_in_ready", {31'd0, in_ready}, 32'd1);
      chk("pp_head", {16'd0, out1_data}, {16'd0, 16'h5000 + 16'(i - 1)});
      step();
    end
    in_valid = 1'b0;
    step();
    step();

    // Counter wrap on port 0 from a clean reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    out0_ready = 1'b1; in_valid = 1'b1; in_sel = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      in_data = 16'(i);
      step();
    end
    in_valid = 1'b0;
    at_neg();
    chk("wrap_cnt0_ffff", {16'd0, cnt0}, 32'h0000_FFFF);
    step();
    at_neg();
    chk("wrap_cnt0_zero", {16'd0, cnt0}, 32'd0);

    // Reset with two words buffered
    out0_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 16'hEE01;
    step();
    in_data = 16'hEE02;
    step();
    in_valid = 1'b0;
    at_neg();
    chk("midrst_full", {31'd0, out0_valid}, 32'd1);
    rst = 1'b1; out0_ready = 1'b1;
    step();
    rst = 1'b0;
    at_neg();
    chk("midrst_valid0", {31'd0, out0_valid}, 32'd0);
    chk("midrst_cnt0", {16'd0, cnt0}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      at_neg();
      chk("midrst_no_reappear", {31'd0, out0_valid}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
